// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state types plus widening and saturating-add helpers for the MAC PE (ACC_W <= 62, ACC_W >= 2*DATA_W)
package mac_pkg;
  localparam int MAX_W = 64;
  typedef enum logic {IDLE, ACC} acc_state_e;
  typedef enum logic {EMPTY, FULL} slot_state_e;
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] p, input bit sgn, input int w);
    logic [MAX_W-1:0] t, m;
    t = p >> (w - 1);
    m = {MAX_W{1'b1}} << w;
    return (sgn && t[0]) ? (p | m) : (p & ~m);
  endfunction
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a, b, input bit sgn, sat, input int w);
    logic signed [MAX_W-1:0] s, hi, lo, one;
    one = 64'sd1;
    s = a + b;
    hi = sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    lo = sgn ? -(one <<< (w - 1)) : '0;
    return {(s > hi) || (s < lo), (sat && s > hi) ? hi : (sat && s < lo) ? lo : s};
  endfunction
endpackage

// File: rtl/mac_mul_pipe.sv
// mac_mul_pipe: w*d multiplier carried with its vld/clr/last tags through MUL_PIPE stall-able stages (CLK, RST, en, w, d, tags in; prod, p_* out)
module mac_mul_pipe #(
  parameter int DATA_W = 8,
  parameter int SIGNED = 1,
  parameter int MUL_PIPE = 1
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic [DATA_W-1:0]   w,
  input  logic [DATA_W-1:0]   d,
  input  logic                vld,
  input  logic                clr,
  input  logic                last,
  output logic [2*DATA_W-1:0] prod,
  output logic                p_vld,
  output logic                p_clr,
  output logic                p_last
);
  localparam int PW = 2 * DATA_W;
  typedef struct packed {
    logic [PW-1:0] p;
    logic vld;
    logic clr;
    logic last;
  } stage_t;
  stage_t pipe [MUL_PIPE];
  logic [PW-1:0] smul, umul;
  assign smul = PW'($signed(w)) * PW'($signed(d));
  assign umul = PW'(w) * PW'(d);
  always_ff @(posedge CLK)
    if (RST) begin
      for (int i = 0; i < MUL_PIPE; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= '{SIGNED != 0 ? smul : umul, vld, clr, last};
      for (int i = 1; i < MUL_PIPE; i++) pipe[i] <= pipe[i-1];
    end
  assign {prod, p_vld, p_clr, p_last} = pipe[MUL_PIPE-1];
endmodule

// File: rtl/mac_pe_os.sv
// mac_pe_os: output-stationary MAC PE; forwards w/d/tags east/south, accumulates tagged tiles, holds one result and drains it down the column chain
module mac_pe_os
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int SIGNED = 1,
  parameter int SATURATE = 1,
  parameter int MUL_PIPE = 1
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              in_vld,
  input  logic              in_clr,
  input  logic              in_last,
  output logic [DATA_W-1:0] w_out,
  output logic [DATA_W-1:0] d_out,
  output logic              vld_out,
  output logic              clr_out,
  output logic              last_out,
  input  logic              shift,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_in_vld,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_vld,
  output logic              ovf,
  output logic              err
);
  localparam int PW = 2 * DATA_W;
  localparam bit SGN = SIGNED != 0;
  localparam bit SAT = SATURATE != 0;
  logic [PW-1:0] prod;
  logic p_vld, p_clr, p_last, ovf_add, done, ovf_n, err_n, rv_n;
  logic [ACC_W-1:0] acc, acc_n, acc_add, acc_clr, slot, slot_n, res_n;
  acc_state_e st, st_n;
  slot_state_e slot_st, slot_st_n;
  mac_mul_pipe #(.DATA_W(DATA_W), .SIGNED(SIGNED), .MUL_PIPE(MUL_PIPE)) u_mul (
    .CLK(CLK), .RST(RST), .en(en), .w(w_in), .d(d_in), .vld(in_vld), .clr(in_clr), .last(in_last),
    .prod(prod), .p_vld(p_vld), .p_clr(p_clr), .p_last(p_last)
  );
  function automatic logic [MAX_W:0] acc_plus(input logic [ACC_W-1:0] a, input logic [PW-1:0] p);
    return sat_add(ext_prod(MAX_W'(a), SGN, ACC_W), ext_prod(MAX_W'(p), SGN, PW), SGN, SAT, ACC_W);
  endfunction
  assign acc_add = ACC_W'(acc_plus(acc, prod));
  assign ovf_add = 1'(acc_plus(acc, prod) >> MAX_W);
  assign acc_clr = ACC_W'(ext_prod(MAX_W'(prod), SGN, PW));
  always_comb begin
    st_n = st;
    slot_st_n = slot_st;
    acc_n = acc;
    slot_n = slot;
    ovf_n = ovf;
    err_n = err;
    res_n = res_out;
    rv_n = res_vld;
    done = 1'b0;
    if (p_vld && (p_clr || st == ACC)) begin
      acc_n = p_clr ? acc_clr : acc_add;
      ovf_n = !p_clr && (ovf || ovf_add);
      st_n = p_last ? IDLE : ACC;
      done = p_last;
    end else if (p_vld) err_n = 1'b1;
    if (shift) begin
      res_n = slot_st == FULL ? slot : res_in;
      rv_n = slot_st == FULL || res_in_vld;
      slot_st_n = EMPTY;
    end
    if (done) begin
      err_n = err || (slot_st == FULL && !shift);
      slot_n = acc_n;
      slot_st_n = FULL;
    end
  end
  always_ff @(posedge CLK)
    if (RST) begin
      {w_out, d_out, vld_out, clr_out, last_out} <= '0;
      st <= IDLE;
      slot_st <= EMPTY;
      acc <= '0;
      slot <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
      res_out <= '0;
      res_vld <= 1'b0;
    end else if (en) begin
      {w_out, d_out, vld_out, clr_out, last_out} <= {w_in, d_in, in_vld, in_clr, in_last};
      st <= st_n;
      slot_st <= slot_st_n;
      acc <= acc_n;
      slot <= slot_n;
      ovf <= ovf_n;
      err <= err_n;
      res_out <= res_n;
      res_vld <= rv_n;
    end
endmodule

// File: tb/tb_mac_pe_os.sv
// tb_mac_pe_os: self-checking bench for mac_pe_os (saturating and wrapping PEs side by side, plus a 4-PE drain column)
module tb_mac_pe_os;
  logic CLK = 0, RST = 1, en = 1, in_vld = 0, in_clr = 0, in_last = 0, shift = 0, res_in_vld = 0;
  logic [7:0] w_in = 0, d_in = 0;
  logic [15:0] res_in = 0;
  logic [7:0] sw_out, sd_out, ww_out, wd_out;
  logic s_vo, s_co, s_lo, w_vo, w_co, w_lo;
  logic [15:0] s_res, w_res;
  logic s_rv, w_rv, s_ovf, w_ovf, s_err, w_err;
  logic [7:0] c_w [4], c_d [4], c_wo [4], c_do [4];
  logic [3:0] c_vld = 0, c_clr = 0, c_last = 0, c_vo, c_co, c_lo, c_ovf, c_err;
  logic c_shift = 0;
  logic [15:0] c_res [5];
  logic c_rv [5];
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  assign c_res[0] = '0;
  assign c_rv[0] = 1'b0;

  mac_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .MUL_PIPE(1)) dut_s (
    .CLK(CLK), .RST(RST), .en(en), .w_in(w_in), .d_in(d_in), .in_vld(in_vld), .in_clr(in_clr), .in_last(in_last),
    .w_out(sw_out), .d_out(sd_out), .vld_out(s_vo), .clr_out(s_co), .last_out(s_lo), .shift(shift),
    .res_in(res_in), .res_in_vld(res_in_vld), .res_out(s_res), .res_vld(s_rv), .ovf(s_ovf), .err(s_err));
  mac_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .MUL_PIPE(1)) dut_w (
    .CLK(CLK), .RST(RST), .en(en), .w_in(w_in), .d_in(d_in), .in_vld(in_vld), .in_clr(in_clr), .in_last(in_last),
    .w_out(ww_out), .d_out(wd_out), .vld_out(w_vo), .clr_out(w_co), .last_out(w_lo), .shift(shift),
    .res_in(res_in), .res_in_vld(res_in_vld), .res_out(w_res), .res_vld(w_rv), .ovf(w_ovf), .err(w_err));
  for (genvar g = 0; g < 4; g++) begin : g_col
    mac_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .MUL_PIPE(1)) pe (
      .CLK(CLK), .RST(RST), .en(en), .w_in(c_w[g]), .d_in(c_d[g]), .in_vld(c_vld[g]), .in_clr(c_clr[g]),
      .in_last(c_last[g]), .w_out(c_wo[g]), .d_out(c_do[g]), .vld_out(c_vo[g]), .clr_out(c_co[g]),
      .last_out(c_lo[g]), .shift(c_shift), .res_in(c_res[g]), .res_in_vld(c_rv[g]), .res_out(c_res[g+1]),
      .res_vld(c_rv[g+1]), .ovf(c_ovf[g]), .err(c_err[g]));
  end

  // Reference tile arithmetic on plain integers: one 16-bit signed accumulation step.
  function automatic longint step(input longint a, input longint p, input bit sat, output bit o);
    longint s;
    s = a + p;
    o = s > 32767 || s < -32768;
    if (sat) s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    else begin
      s = s & 64'hFFFF;
      if (s > 32767) s -= 65536;
    end
    return s;
  endfunction

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic flush(); repeat (3) tick(); endtask
  task automatic do_reset(); RST = 1; tick(); RST = 0; endtask
  task automatic do_shift(); shift = 1; tick(); shift = 0; endtask
  task automatic drive(input logic [7:0] w, input logic [7:0] d, input logic c, input logic l, input logic sh);
    w_in = w; d_in = d; in_vld = 1; in_clr = c; in_last = l; shift = sh;
    tick();
    in_vld = 0; in_clr = 0; in_last = 0; shift = 0;
  endtask

  task automatic test_reset();
    RST = 1; tick(); tick(); RST = 0;
    checks++; if (s_res !== 16'd0) begin failures++; $display("FAIL reset_res got=%0h exp=0", s_res); end
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", s_rv); end
    checks++; if ({s_ovf, s_err, w_ovf, w_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {s_ovf, s_err, w_ovf, w_err}); end
    checks++; if ({sw_out, sd_out, s_vo, s_co, s_lo} !== 19'd0) begin failures++; $display("FAIL reset_fwd got=%0h exp=0", {sw_out, sd_out, s_vo, s_co, s_lo}); end
  endtask

  task automatic test_basic();
    drive(8'd3, 8'd4, 1, 0, 0);
    checks++; if ({sw_out, sd_out, s_vo, s_co, s_lo} !== {8'd3, 8'd4, 3'b110}) begin failures++; $display("FAIL fwd got=%0h exp=%0h", {sw_out, sd_out, s_vo, s_co, s_lo}, {8'd3, 8'd4, 3'b110}); end
    drive(8'hFE, 8'd5, 0, 0, 0);
    drive(8'd7, 8'd7, 0, 1, 0);
    checks++; if ({s_vo, s_lo, w_vo} !== 3'b111) begin failures++; $display("FAIL fwd_last got=%b exp=111", {s_vo, s_lo, w_vo}); end
    flush();
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL basic_pre_shift_rv got=%b exp=0", s_rv); end
    do_shift();
    checks++; if (s_res !== 16'd51 || s_rv !== 1'b1) begin failures++; $display("FAIL basic_res got=%0d/%b exp=51/1", s_res, s_rv); end
    checks++; if (w_res !== 16'd51) begin failures++; $display("FAIL basic_res_wrap got=%0d exp=51", w_res); end
    do_shift();
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL empty_shift_rv got=%b exp=0", s_rv); end
  endtask

  task automatic test_overflow();
    drive(8'd127, 8'd127, 1, 0, 0);
    drive(8'd127, 8'd127, 0, 0, 0);
    drive(8'd127, 8'd127, 0, 1, 0);
    flush();
    checks++; if ({s_ovf, w_ovf} !== 2'b11) begin failures++; $display("FAIL ovf_flag got=%b exp=11", {s_ovf, w_ovf}); end
    do_shift();
    checks++; if (s_res !== 16'd32767) begin failures++; $display("FAIL sat_res got=%0h exp=7fff", s_res); end
    checks++; if (w_res !== 16'hBD03) begin failures++; $display("FAIL wrap_res got=%0h exp=bd03", w_res); end
    drive(8'd1, 8'd1, 1, 1, 0);
    flush();
    checks++; if ({s_ovf, w_ovf} !== 2'b00) begin failures++; $display("FAIL ovf_clear got=%b exp=00", {s_ovf, w_ovf}); end
    do_shift();
  endtask

  task automatic test_stall();
    logic [15:0] r0;
    logic v0;
    r0 = s_res; v0 = s_rv;
    drive(8'd3, 8'd4, 1, 0, 0);
    en = 0; w_in = 8'h55; d_in = 8'h66; in_vld = 1; in_clr = 1; in_last = 1; shift = 1;
    repeat (5) tick();
    checks++; if ({sw_out, sd_out, s_vo, s_co, s_lo} !== {8'd3, 8'd4, 3'b110}) begin failures++; $display("FAIL stall_fwd got=%0h exp=%0h", {sw_out, sd_out, s_vo, s_co, s_lo}, {8'd3, 8'd4, 3'b110}); end
    checks++; if (s_res !== r0 || s_rv !== v0 || s_err !== 1'b0) begin failures++; $display("FAIL stall_res got=%0h/%b/%b exp=%0h/%b/0", s_res, s_rv, s_err, r0, v0); end
    en = 1; in_vld = 0; in_clr = 0; in_last = 0; shift = 0;
    drive(8'hFE, 8'd5, 0, 0, 0);
    drive(8'd7, 8'd7, 0, 1, 0);
    flush();
    do_shift();
    checks++; if (s_res !== 16'd51 || s_err !== 1'b0) begin failures++; $display("FAIL stall_result got=%0d err=%b exp=51 err=0", s_res, s_err); end
  endtask

  task automatic test_back_to_back();
    drive(8'd2, 8'd3, 1, 0, 0);
    drive(8'd4, 8'd5, 0, 1, 0);
    drive(8'd1, 8'd1, 1, 0, 0);
    drive(8'd6, 8'hFD, 0, 0, 1);
    checks++; if (s_res !== 16'd26 || s_rv !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=26/1", s_res, s_rv); end
    drive(8'd2, 8'd2, 0, 1, 0);
    flush();
    do_shift();
    checks++; if (s_res !== 16'hFFF3 || s_err !== 1'b0) begin failures++; $display("FAIL b2b_second got=%0h err=%b exp=fff3 err=0", s_res, s_err); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int n;
      longint p, a_s, a_w;
      bit o_s, o_w, o;
      logic [7:0] w, d;
      n = $urandom_range(1, 6);
      a_s = 0; a_w = 0; o_s = 0; o_w = 0;
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom); d = 8'($urandom);
        p = longint'($signed(w)) * longint'($signed(d));
        if (i == 0) begin a_s = p; a_w = p; end
        else begin
          a_s = step(a_s, p, 1'b1, o); o_s |= o;
          a_w = step(a_w, p, 1'b0, o); o_w |= o;
        end
        drive(w, d, i == 0, i == n - 1, 0);
      end
      flush();
      checks++; if ({s_ovf, w_ovf} !== {o_s, o_w}) begin failures++; $display("FAIL rand_ovf t=%0d got=%b exp=%b", t, {s_ovf, w_ovf}, {o_s, o_w}); end
      do_shift();
      checks++; if (s_res !== 16'(a_s) || s_rv !== 1'b1) begin failures++; $display("FAIL rand_sat t=%0d got=%0h exp=%0h", t, s_res, 16'(a_s)); end
      checks++; if (w_res !== 16'(a_w)) begin failures++; $display("FAIL rand_wrap t=%0d got=%0h exp=%0h", t, w_res, 16'(a_w)); end
    end
    checks++; if ({s_err, w_err} !== 2'b00) begin failures++; $display("FAIL rand_err got=%b exp=00", {s_err, w_err}); end
  endtask

  task automatic test_overrun();
    do_reset();
    drive(8'd1, 8'd10, 1, 1, 0);
    flush();
    drive(8'd3, 8'd10, 1, 1, 0);
    shift = 1; tick(); shift = 0;
    checks++; if (s_res !== 16'd10 || s_rv !== 1'b1 || s_err !== 1'b0) begin failures++; $display("FAIL same_cycle got=%0d/%b err=%b exp=10/1 err=0", s_res, s_rv, s_err); end
    do_shift();
    checks++; if (s_res !== 16'd30 || s_err !== 1'b0) begin failures++; $display("FAIL same_cycle_new got=%0d err=%b exp=30 err=0", s_res, s_err); end
    drive(8'd2, 8'd10, 1, 1, 0);
    flush();
    drive(8'd4, 8'd10, 1, 1, 0);
    flush();
    checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL overrun_err got=%b exp=1", s_err); end
    do_shift();
    checks++; if (s_res !== 16'd40) begin failures++; $display("FAIL overrun_res got=%0d exp=40", s_res); end
  endtask

  task automatic test_mid_reset();
    drive(8'd1, 8'd7, 1, 1, 0);
    flush();
    drive(8'd5, 8'd5, 1, 0, 0);
    do_reset();
    checks++; if ({s_res, s_rv, s_ovf, s_err, sw_out, sd_out, s_vo} !== 43'd0) begin failures++; $display("FAIL mid_reset got=%0h exp=0", {s_res, s_rv, s_ovf, s_err, sw_out, sd_out, s_vo}); end
    flush();
    do_shift();
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL reset_slot_rv got=%b exp=0", s_rv); end
    drive(8'd2, 8'd3, 0, 1, 0);
    flush();
    checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL untagged_err got=%b exp=1", s_err); end
    do_shift();
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL untagged_drop got=%b exp=0", s_rv); end
    drive(8'd2, 8'd3, 1, 1, 0);
    flush();
    do_shift();
    checks++; if (s_res !== 16'd6) begin failures++; $display("FAIL after_untagged got=%0d exp=6", s_res); end
  endtask

  task automatic test_column();
    do_reset();
    for (int i = 0; i < 4; i++) begin c_w[i] = 8'd1; c_d[i] = 8'(10 * (i + 1)); end
    c_vld = 4'hF; c_clr = 4'hF; c_last = 4'hF;
    tick();
    c_vld = 0; c_clr = 0; c_last = 0;
    flush();
    for (int k = 0; k < 4; k++) begin
      c_shift = 1; tick(); c_shift = 0;
      checks++; if (c_res[4] !== 16'(40 - 10 * k) || c_rv[4] !== 1'b1) begin failures++; $display("FAIL column k=%0d got=%0d/%b exp=%0d/1", k, c_res[4], c_rv[4], 40 - 10 * k); end
    end
    c_shift = 1; tick(); c_shift = 0;
    checks++; if (c_rv[4] !== 1'b0 || c_err !== 4'b0) begin failures++; $display("FAIL column_end got=%b err=%b exp=0 err=0000", c_rv[4], c_err); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin c_w[i] = 0; c_d[i] = 0; end
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_random();
    test_overrun();
    test_mid_reset();
    test_column();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
